// File: rtl/axi_10g_ethernet_0_rx_reset_sequencer.sv
// Per-lane RX reset sequencer for the 10GBASE-R GT/PCS channel.
// Brings the GT receiver out of reset in order (gtrxreset -> rxresetdone ->
// rxuserrdy -> PCS reset release), then supervises block lock and restarts
// the sequence on timeout or sustained lock loss. Runs entirely in coreclk.
module axi_10g_ethernet_0_rx_reset_sequencer #(
   parameter int unsigned GTRXRESET_CYCLES  = 16,
   parameter int unsigned RESETDONE_TIMEOUT = 4096,
   parameter int unsigned LOCK_TIMEOUT      = 65536,
   parameter int unsigned LOSS_DEBOUNCE     = 64,
   parameter int unsigned RETRY_W           = 4
) (
   input  logic               coreclk,
   input  logic               reset_n,
   input  logic               reset_counter_done,
   input  logic               qplllock,
   input  logic               rxresetdone,
   input  logic               block_lock,
   output logic               gtrxreset,
   output logic               rxuserrdy,
   output logic               rx_pcs_reset,
   output logic               rx_ready,
   output logic [RETRY_W-1:0] retry_count,
   output logic [2:0]         state_dbg
);

   // Timer is sized to the largest of the three timed intervals.
   localparam int unsigned MAX_A = (GTRXRESET_CYCLES > RESETDONE_TIMEOUT) ?
                                   GTRXRESET_CYCLES : RESETDONE_TIMEOUT;
   localparam int unsigned MAX_T = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
   localparam int unsigned TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   localparam int unsigned DW    = $clog2(LOSS_DEBOUNCE + 1);

   // Loading PARAM-1 makes the timer hit zero on the PARAM-th cycle in a state.
   localparam logic [TW-1:0] LOAD_RST  = TW'(GTRXRESET_CYCLES - 1);
   localparam logic [TW-1:0] LOAD_DONE = TW'(RESETDONE_TIMEOUT - 1);
   localparam logic [TW-1:0] LOAD_LOCK = TW'(LOCK_TIMEOUT - 1);
   localparam logic [DW-1:0] LOSS_LAST = DW'(LOSS_DEBOUNCE - 1);

   typedef enum logic [2:0] {
      WAIT_INIT  = 3'd0,
      ASSERT_RST = 3'd1,
      WAIT_DONE  = 3'd2,
      SET_RDY    = 3'd3,
      WAIT_LOCK  = 3'd4,
      READY      = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [DW-1:0]        debounce_q, debounce_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 retry_hit;

   logic                 qpll_meta_q, qpll_meta_d;
   logic                 qpll_s_q, qpll_s_d;
   logic                 rxrd_meta_q, rxrd_meta_d;
   logic                 rxrd_s_q, rxrd_s_d;

   logic                 gtrxreset_q, gtrxreset_d;
   logic                 rxuserrdy_q, rxuserrdy_d;
   logic                 rx_pcs_reset_q, rx_pcs_reset_d;
   logic                 rx_ready_q, rx_ready_d;

   // Two-flop synchronizers for the asynchronous GT status inputs.
   always_comb begin
      qpll_meta_d = qplllock;
      qpll_s_d    = qpll_meta_q;
      rxrd_meta_d = rxresetdone;
      rxrd_s_d    = rxrd_meta_q;
   end

   // State register plus timer, debounce, retry, synchronizer and output flops.
   always_ff @(posedge coreclk) begin
      if (!reset_n) begin
         state_q        <= WAIT_INIT;
         timer_q        <= '0;
         debounce_q     <= '0;
         retry_q        <= '0;
         qpll_meta_q    <= 1'b0;
         qpll_s_q       <= 1'b0;
         rxrd_meta_q    <= 1'b0;
         rxrd_s_q       <= 1'b0;
         gtrxreset_q    <= 1'b1;
         rxuserrdy_q    <= 1'b0;
         rx_pcs_reset_q <= 1'b1;
         rx_ready_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         debounce_q     <= debounce_d;
         retry_q        <= retry_d;
         qpll_meta_q    <= qpll_meta_d;
         qpll_s_q       <= qpll_s_d;
         rxrd_meta_q    <= rxrd_meta_d;
         rxrd_s_q       <= rxrd_s_d;
         gtrxreset_q    <= gtrxreset_d;
         rxuserrdy_q    <= rxuserrdy_d;
         rx_pcs_reset_q <= rx_pcs_reset_d;
         rx_ready_q     <= rx_ready_d;
      end
   end

   // Next-state decision; QPLL loss overrides everything, success beats timeout.
   always_comb begin
      state_d   = state_q;
      retry_hit = 1'b0;
      case (state_q)
         WAIT_INIT: begin
            if (reset_counter_done && qpll_s_q) state_d = ASSERT_RST;
         end
         ASSERT_RST: begin
            if (timer_q == '0) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (rxrd_s_q)           state_d   = SET_RDY;
            else if (timer_q == '0) retry_hit = 1'b1;
         end
         SET_RDY: begin
            state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (block_lock)         state_d   = READY;
            else if (timer_q == '0) retry_hit = 1'b1;
         end
         READY: begin
            if (!block_lock && (debounce_q == LOSS_LAST)) retry_hit = 1'b1;
         end
         default: begin
            state_d = WAIT_INIT;
         end
      endcase
      if (retry_hit) state_d = ASSERT_RST;
      if ((state_q != WAIT_INIT) && !qpll_s_q) begin
         state_d   = WAIT_INIT;
         retry_hit = 1'b0;
      end
   end

   // Timer reloads on every state change, otherwise counts down to zero.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         case (state_d)
            ASSERT_RST: timer_d = LOAD_RST;
            WAIT_DONE:  timer_d = LOAD_DONE;
            WAIT_LOCK:  timer_d = LOAD_LOCK;
            default:    timer_d = '0;
         endcase
      end else if (timer_q != '0) begin
         timer_d = timer_q - TW'(1);
      end
   end

   // Consecutive block_lock-low counter in READY; saturating retry counter.
   always_comb begin
      debounce_d = '0;
      if ((state_q == READY) && (state_d == READY) && !block_lock)
         debounce_d = debounce_q + DW'(1);
      retry_d = retry_q;
      if (retry_hit && (retry_q != '1))
         retry_d = retry_q + RETRY_W'(1);
   end

   // Output decode from the next state so registered outputs track state_q.
   always_comb begin
      gtrxreset_d    = 1'b0;
      rxuserrdy_d    = 1'b0;
      rx_pcs_reset_d = 1'b0;
      rx_ready_d     = 1'b0;
      case (state_d)
         WAIT_INIT, ASSERT_RST: begin
            gtrxreset_d    = 1'b1;
            rx_pcs_reset_d = 1'b1;
         end
         WAIT_DONE: begin
            rx_pcs_reset_d = 1'b1;
         end
         SET_RDY: begin
            rxuserrdy_d    = 1'b1;
            rx_pcs_reset_d = 1'b1;
         end
         WAIT_LOCK: begin
            rxuserrdy_d    = 1'b1;
         end
         READY: begin
            rxuserrdy_d    = 1'b1;
            rx_ready_d     = 1'b1;
         end
         default: begin
            gtrxreset_d    = 1'b1;
            rx_pcs_reset_d = 1'b1;
         end
      endcase
   end

   assign gtrxreset    = gtrxreset_q;
   assign rxuserrdy    = rxuserrdy_q;
   assign rx_pcs_reset = rx_pcs_reset_q;
   assign rx_ready     = rx_ready_q;
   assign retry_count  = retry_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_rx_reset_sequencer.sv
// Bench for the RX reset sequencer: directed bring-up/fault scenarios followed
// by randomized inputs, all checked cycle by cycle against a phase/age model.
module tb_axi_10g_ethernet_0_rx_reset_sequencer;

   localparam int G  = 16;
   localparam int RD = 200;
   localparam int LT = 300;
   localparam int LD = 64;
   localparam int RW = 4;
   localparam int RMAX = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          reset_counter_done = 1'b0;
   logic          qplllock = 1'b0;
   logic          rxresetdone = 1'b0;
   logic          block_lock = 1'b0;
   logic          gtrxreset, rxuserrdy, rx_pcs_reset, rx_ready;
   logic [RW-1:0] retry_count;
   logic [2:0]    state_dbg;

   axi_10g_ethernet_0_rx_reset_sequencer #(
      .GTRXRESET_CYCLES (G),
      .RESETDONE_TIMEOUT(RD),
      .LOCK_TIMEOUT     (LT),
      .LOSS_DEBOUNCE    (LD),
      .RETRY_W          (RW)
   ) dut (
      .coreclk           (clk),
      .reset_n           (reset_n),
      .reset_counter_done(reset_counter_done),
      .qplllock          (qplllock),
      .rxresetdone       (rxresetdone),
      .block_lock        (block_lock),
      .gtrxreset         (gtrxreset),
      .rxuserrdy         (rxuserrdy),
      .rx_pcs_reset      (rx_pcs_reset),
      .rx_ready          (rx_ready),
      .retry_count       (retry_count),
      .state_dbg         (state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus settings held across cycles
   bit s_rn = 1'b0, s_rcd = 1'b0, s_qpll = 1'b0, s_rxrd = 1'b0, s_bl = 1'b0;

   // Reference model: phase number, cycles spent in phase, low-run length,
   // retries, and delay lines standing in for the synchronizers.
   int m_phase = 0;
   int m_age   = 1;
   int m_low   = 0;
   int m_retry = 0;
   bit qh[$] = '{1'b0, 1'b0};
   bit rh[$] = '{1'b0, 1'b0};

   logic [10:0] exp_q[$];

   task automatic model_step(input bit rn, input bit rcd, input bit q,
                             input bit r, input bit bl);
      bit qs, rs, fail;
      int nxt;
      if (!rn) begin
         m_phase = 0; m_age = 1; m_low = 0; m_retry = 0;
         qh = '{1'b0, 1'b0};
         rh = '{1'b0, 1'b0};
      end else begin
         qs = qh[0]; rs = rh[0]; fail = 1'b0; nxt = m_phase;
         if (m_phase != 0 && !qs) nxt = 0;
         else begin
            case (m_phase)
               0: if (rcd && qs) nxt = 1;
               1: if (m_age == G) nxt = 2;
               2: if (rs) nxt = 3; else if (m_age == RD) fail = 1'b1;
               3: nxt = 4;
               4: if (bl) nxt = 5; else if (m_age == LT) fail = 1'b1;
               default: begin
                  m_low = bl ? 0 : m_low + 1;
                  if (m_low == LD) fail = 1'b1;
               end
            endcase
         end
         if (fail) begin
            nxt = 1;
            if (m_retry < RMAX) m_retry++;
         end
         if (nxt != m_phase) begin m_age = 1; m_low = 0; end
         else m_age++;
         m_phase = nxt;
         void'(qh.pop_front()); qh.push_back(q);
         void'(rh.pop_front()); rh.push_back(r);
      end
   endtask

   function automatic logic [10:0] model_out();
      logic gt, ur, pcs, rdy;
      gt  = (m_phase <= 1);
      ur  = (m_phase >= 3);
      pcs = (m_phase <= 3);
      rdy = (m_phase == 5);
      return {gt, ur, pcs, rdy, RW'(m_retry), 3'(m_phase)};
   endfunction

   // One clock of stimulus: drive on the falling edge, queue the expectation.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset_n            = s_rn;
         reset_counter_done = s_rcd;
         qplllock           = s_qpll;
         rxresetdone        = s_rxrd;
         block_lock         = s_bl;
         model_step(s_rn, s_rcd, s_qpll, s_rxrd, s_bl);
         exp_q.push_back(model_out());
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: one expectation consumed per clock edge.
   initial begin
      logic [10:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {gtrxreset, rxuserrdy, rx_pcs_reset, rx_ready, retry_count, state_dbg};
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t actual=%b required=%b", $time, a, e);
            end
         end
      end
   end

   initial begin
      int k;
      // Reset and nominal bring-up
      s_rn = 0; cyc(4);
      settle();
      chk("reset_vec", {gtrxreset, rxuserrdy, rx_pcs_reset, rx_ready, retry_count, state_dbg},
          {21'd0, 11'b1_0_1_0_0000_000});
      s_rn = 1; s_rcd = 1; s_qpll = 1;
      cyc(18);
      settle(); chk("gtrxreset_held_16", gtrxreset, 1);
      cyc(1);
      settle(); chk("gtrxreset_released", gtrxreset, 0);
      cyc(99);
      s_rxrd = 1; cyc(2);
      settle(); chk("rxuserrdy_not_yet", rxuserrdy, 0);
      cyc(1);
      settle(); chk("rxuserrdy_rise", rxuserrdy, 1);
      chk("state_set_rdy", state_dbg, 3);
      cyc(1);
      settle(); chk("pcs_reset_release", rx_pcs_reset, 0);
      s_bl = 1; cyc(1);
      settle(); chk("rx_ready_up", rx_ready, 1);
      chk("retry_zero", retry_count, 0);
      cyc(10);

      // Lock loss debounce
      s_bl = 0; cyc(63);
      settle(); chk("loss_63_kept", rx_ready, 1);
      s_bl = 1; cyc(5);
      s_bl = 0; cyc(63);
      settle(); chk("loss_63_kept_b", rx_ready, 1);
      cyc(1);
      settle(); chk("loss_64_drop", rx_ready, 0);
      chk("loss_retry", retry_count, 1);

      // rxresetdone never rises: exact timeout then saturation
      s_rxrd = 0; cyc(G);
      cyc(RD - 1);
      settle(); chk("done_timeout_pre", gtrxreset, 0);
      cyc(1);
      settle(); chk("done_timeout_hit", gtrxreset, 1);
      chk("done_timeout_retry", retry_count, 2);
      cyc(20 * (G + RD));
      settle(); chk("retry_saturated", retry_count, RMAX);

      // reset_n pulse during WAIT_DONE
      k = 0;
      while (m_phase != 2 && k < 1000) begin cyc(1); k++; end
      if (k >= 1000) chk("reach_wait_done_bound", k, 0);
      cyc(5);
      s_rn = 0; cyc(1);
      settle();
      chk("midreset_vec", {gtrxreset, rxuserrdy, rx_pcs_reset, rx_ready, retry_count, state_dbg},
          {21'd0, 11'b1_0_1_0_0000_000});
      s_rn = 1; cyc(30);
      settle(); chk("restart_wait_done", state_dbg, 2);

      // QPLL loss in WAIT_LOCK on the same cycle block_lock rises
      s_rxrd = 1; cyc(5);
      settle(); chk("in_wait_lock", state_dbg, 4);
      s_qpll = 0; cyc(2);
      s_bl = 1; cyc(1);
      settle(); chk("qpll_loss_state", state_dbg, 0);
      chk("qpll_loss_ready", rx_ready, 0);
      chk("qpll_loss_gtrst", gtrxreset, 1);
      chk("qpll_loss_retry", retry_count, 0);

      // rxresetdone_s arrives on the timeout cycle
      s_bl = 0; s_rxrd = 0; s_qpll = 1;
      k = 0;
      while (!(m_phase == 2 && m_age == RD - 2) && k < 2000) begin cyc(1); k++; end
      if (k >= 2000) chk("reach_boundary_bound", k, 0);
      s_rxrd = 1; cyc(3);
      settle(); chk("tie_success_state", state_dbg, 3);
      chk("tie_no_retry", retry_count, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s_rn  = ($urandom_range(0, 299) != 0);
         s_rcd = ($urandom_range(0, 49) != 0);
         if (s_qpll) begin if ($urandom_range(0, 399) == 0) s_qpll = 0; end
         else if ($urandom_range(0, 7) == 0) s_qpll = 1;
         if ($urandom_range(0, 39) == 0) s_rxrd = ~s_rxrd;
         if ($urandom_range(0, 24) == 0) s_bl = ~s_bl;
         cyc(1);
      end

      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
